// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: Memory-stage access sequencer for the Y86-64 pipeline.
// Decodes M_icode, runs one req/ack transaction per memory instruction
// against a variable-latency data memory, stalls the pipeline until the
// access completes, and produces m_valM / m_stat for the W register.
module mem_access_ctrl #(
    parameter int MEM_BYTES = 8192,
    parameter int TIMEOUT   = 16,
    parameter int CNT_W     = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  M_stat,
    input  logic [3:0]  M_icode,
    input  logic [63:0] M_valE,
    input  logic [63:0] M_valA,
    input  logic        dmem_ack,
    input  logic [63:0] dmem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic        mem_stall,
    output logic [63:0] m_valM,
    output logic [2:0]  m_stat
);

    // Status codes shared with the rest of the pipeline.
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SADR = 3'd3;

    // Memory-referencing instruction codes.
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Highest legal start address of an 8-byte word; compared unsigned.
    localparam logic [63:0] MAX_ADDR  = 64'(MEM_BYTES - 8);
    // Counter value of the last REQ cycle before the access times out.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [2:0]       stat_q;

    logic             op_read;
    logic             op_write;
    logic             op_use_vala;
    logic             op_mem;
    logic [63:0]      op_addr;
    logic             addr_ok;
    logic             launch;
    logic             bad_addr;
    logic             timed_out;

    // Decode the icode into read/write class and address source.
    // NOTE: every variable assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        op_read     = 1'b0;
        op_write    = 1'b0;
        op_use_vala = 1'b0;
        case (M_icode)
            I_MRMOVQ: op_read = 1'b1;
            I_POPQ: begin
                op_read     = 1'b1;
                op_use_vala = 1'b1;
            end
            I_RET: begin
                op_read     = 1'b1;
                op_use_vala = 1'b1;
            end
            I_RMMOVQ: op_write = 1'b1;
            I_PUSHQ:  op_write = 1'b1;
            I_CALL:   op_write = 1'b1;
            default: begin
                op_read     = 1'b0;
                op_write    = 1'b0;
                op_use_vala = 1'b0;
            end
        endcase
    end

    // Launch qualification: healthy instruction, memory op, address in range.
    assign op_mem    = op_read | op_write;
    assign op_addr   = op_use_vala ? M_valA : M_valE;
    assign addr_ok   = (op_addr <= MAX_ADDR);
    assign launch    = (M_stat == SAOK) && op_mem && addr_ok;
    assign bad_addr  = (M_stat == SAOK) && op_mem && !addr_ok;
    assign timed_out = !dmem_ack && (wait_cnt == CNT_LAST);

    // State register.
    // NOTE: sequential blocks use non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and combinational stall/status outputs.
    always_comb begin
        state_next = state;
        mem_stall  = 1'b0;
        m_stat     = M_stat;
        case (state)
            S_IDLE: begin
                if (launch) begin
                    mem_stall  = 1'b1;
                    state_next = S_REQ;
                end else if (bad_addr) begin
                    m_stat = SADR;
                end
            end
            S_REQ: begin
                mem_stall = 1'b1;
                if (dmem_ack || timed_out) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                // The pipeline advances at the end of this cycle.
                m_stat     = stat_q;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Request/address/data registers, timeout counter, load data and status.
    always_ff @(posedge clk) begin
        if (reset) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            m_valM     <= '0;
            wait_cnt   <= '0;
            stat_q     <= SAOK;
        end else begin
            // Request is high exactly for the cycles spent in REQ.
            dmem_req <= (state_next == S_REQ);
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        dmem_we    <= op_write;
                        dmem_addr  <= op_addr;
                        dmem_wdata <= M_valA;
                        wait_cnt   <= '0;
                    end
                end
                S_REQ: begin
                    if (dmem_ack) begin
                        if (!dmem_we) begin
                            m_valM <= dmem_rdata;
                        end
                        stat_q <= SAOK;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (timed_out) begin
                            stat_q <= SADR;
                        end
                    end
                end
                default: begin
                    // DONE: nothing to capture; acks outside REQ are ignored.
                end
            endcase
        end
    end

endmodule
